// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply/divide unit for the DX stage.
// Iterates one bit per cycle on operand magnitudes (shift-add for mult,
// restoring shift-subtract for div) and applies the sign at completion.
// Ports:
//   clock, reset         : rising-edge clock, async active-high reset
//   DXIR                 : instruction in DX; decodes mult/div
//   operandA, operandB   : signed rs / rt operands, sampled at start
//   stall                : combinational pipeline freeze (PC, FD, DX)
//   resultRDY            : one-cycle pulse when result/exception/rdOut valid
//   result, exception    : signed product/quotient and overflow/div-by-zero flag
//   rdOut                : destination register captured from DXIR[26:22]
module multdiv_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] DXIR,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    output logic        stall,
    output logic        resultRDY,
    output logic [31:0] result,
    output logic        exception,
    output logic [4:0]  rdOut
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;
    localparam int unsigned RW = 5;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic [W-1:0]    bmag_q, bmag_d;
    logic            is_div_q, is_div_d;
    logic            neg_q, neg_d;
    logic            divzero_q, divzero_d;
    logic [RW-1:0]   rd_q, rd_d;
    logic [W-1:0]    result_q, result_d;
    logic            exc_q, exc_d;
    logic [RW-1:0]   rd_out_q, rd_out_d;
    logic            rdy_q, rdy_d;

    logic            is_mult_c, is_div_c, start_c, stall_c;
    logic [W-1:0]    a_mag_c, b_mag_c;
    logic [W:0]      msum_c;
    logic [W:0]      dshift_c;
    logic [W+1:0]    ddiff_c;
    logic [W-1:0]    iter_hi_c, iter_lo_c;
    logic [2*W-1:0]  prod_c, sprod_c;
    logic [W-1:0]    quot_c;
    logic            unused_bits;

    // Instruction decode and operand magnitudes
    assign is_mult_c = (DXIR[31:27] == 5'd0) && (DXIR[6:2] == 5'd6);
    assign is_div_c  = (DXIR[31:27] == 5'd0) && (DXIR[6:2] == 5'd7);
    assign start_c   = is_mult_c | is_div_c;
    assign a_mag_c   = operandA[W-1] ? (W'(0) - operandA) : operandA;
    assign b_mag_c   = operandB[W-1] ? (W'(0) - operandB) : operandB;

    // One iteration of either algorithm; hi holds partial product / remainder,
    // lo holds the multiplier being shifted out / quotient being shifted in.
    always_comb begin
        msum_c    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, bmag_q} : (W+1)'(0));
        dshift_c  = {hi_q, lo_q[W-1]};
        ddiff_c   = {1'b0, dshift_c} - {2'b00, bmag_q};
        iter_hi_c = hi_q;
        iter_lo_c = lo_q;
        if (is_div_q) begin
            iter_hi_c = ddiff_c[W+1] ? dshift_c[W-1:0] : ddiff_c[W-1:0];
            iter_lo_c = {lo_q[W-2:0], ~ddiff_c[W+1]};
        end else begin
            iter_hi_c = msum_c[W:1];
            iter_lo_c = {msum_c[0], lo_q[W-1:1]};
        end
    end

    // Sign application on the final iteration's magnitudes
    assign prod_c  = {iter_hi_c, iter_lo_c};
    assign sprod_c = neg_q ? ((2*W)'(0) - prod_c) : prod_c;
    assign quot_c  = neg_q ? (W'(0) - iter_lo_c) : iter_lo_c;

    // Next-state and control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        bmag_d    = bmag_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        divzero_d = divzero_q;
        rd_d      = rd_q;
        result_d  = result_q;
        exc_d     = exc_q;
        rd_out_d  = rd_out_q;
        rdy_d     = 1'b0;
        stall_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_c) begin
                    stall_c   = 1'b1;
                    state_d   = BUSY;
                    cnt_d     = '0;
                    hi_d      = '0;
                    lo_d      = a_mag_c;
                    bmag_d    = b_mag_c;
                    is_div_d  = is_div_c;
                    neg_d     = operandA[W-1] ^ operandB[W-1];
                    divzero_d = (operandB == '0);
                    rd_d      = DXIR[26:22];
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                hi_d    = iter_hi_c;
                lo_d    = iter_lo_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d  = DONE;
                    rdy_d    = 1'b1;
                    rd_out_d = rd_q;
                    if (is_div_q) begin
                        // Only +2^31 (from 0x80000000 / -1) overflows a quotient
                        result_d = divzero_q ? '0 : quot_c;
                        exc_d    = divzero_q | (~neg_q & iter_lo_c[W-1]);
                    end else begin
                        result_d = sprod_c[W-1:0];
                        exc_d    = (sprod_c[2*W-1:W] != {W{sprod_c[W-1]}});
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            bmag_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            divzero_q <= 1'b0;
            rd_q      <= '0;
            result_q  <= '0;
            exc_q     <= 1'b0;
            rd_out_q  <= '0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            bmag_q    <= bmag_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            divzero_q <= divzero_d;
            rd_q      <= rd_d;
            result_q  <= result_d;
            exc_q     <= exc_d;
            rd_out_q  <= rd_out_d;
            rdy_q     <= rdy_d;
        end
    end

    // Stall must drop while reset is held even if DXIR decodes as mult/div
    assign stall     = stall_c & ~reset;
    assign resultRDY = rdy_q;
    assign result    = result_q;
    assign exception = exc_q;
    assign rdOut     = rd_out_q;

    assign unused_bits = ^{DXIR[21:7], DXIR[1:0], ddiff_c[W]};

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed self-checking bench for multdiv_unit.
module tb_multdiv_unit;

    logic        clock;
    logic        reset;
    logic [31:0] DXIR;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        stall;
    logic        resultRDY;
    logic [31:0] result;
    logic        exception;
    logic [4:0]  rdOut;

    int n_cmp  = 0;
    int n_fail = 0;

    multdiv_unit dut (
        .clock     (clock),
        .reset     (reset),
        .DXIR      (DXIR),
        .operandA  (operandA),
        .operandB  (operandB),
        .stall     (stall),
        .resultRDY (resultRDY),
        .result    (result),
        .exception (exception),
        .rdOut     (rdOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd);
        return {5'd0, rd, 15'd0, op, 2'b00};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present an op in the current cycle (T) and check the whole T..T+33 window.
    // Returns in cycle T+33 (the DONE cycle); DXIR is left holding the op.
    task automatic run_op(input string tag, input logic div, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_exc);
        DXIR     = enc(div ? 5'd7 : 5'd6, rd);
        operandA = a;
        operandB = b;
        #1;
        check({tag, " stall@T"}, 32'(stall), 32'd1);
        check({tag, " rdy@T"}, 32'(resultRDY), 32'd0);
        for (int i = 1; i <= 32; i++) begin
            @(posedge clock);
            #1;
            operandA = $urandom;
            operandB = $urandom;
            #1;
            check({tag, " stall busy"}, 32'(stall), 32'd1);
            check({tag, " rdy busy"}, 32'(resultRDY), 32'd0);
        end
        step();
        #1;
        check({tag, " rdy@T+33"}, 32'(resultRDY), 32'd1);
        check({tag, " stall@T+33"}, 32'(stall), 32'd0);
        check({tag, " result"}, result, exp_res);
        check({tag, " exception"}, 32'(exception), 32'(exp_exc));
        check({tag, " rdOut"}, 32'(rdOut), 32'(rd));
    endtask

    localparam logic [31:0] NOP = 32'd0;

    initial begin
        reset    = 1'b1;
        DXIR     = enc(5'd6, 5'd9);
        operandA = 32'd3;
        operandB = 32'd4;
        #2;
        check("reset stall", 32'(stall), 32'd0);
        check("reset rdy", 32'(resultRDY), 32'd0);
        check("reset result", result, 32'd0);
        check("reset exc", 32'(exception), 32'd0);
        check("reset rdOut", 32'(rdOut), 32'd0);
        step();
        step();
        DXIR  = NOP;
        reset = 1'b0;

        // add instruction leaves the unit idle
        step();
        DXIR = enc(5'd0, 5'd2);
        for (int i = 0; i < 40; i++) begin
            #1;
            check("add stall", 32'(stall), 32'd0);
            check("add rdy", 32'(resultRDY), 32'd0);
            step();
        end

        run_op("mul 7x-6", 1'b0, 5'd3, 32'd7, 32'hFFFFFFFA, 32'hFFFFFFD6, 1'b0);
        step();
        DXIR = NOP;
        #1;
        check("post-done rdy", 32'(resultRDY), 32'd0);
        for (int i = 0; i < 3; i++) step();
        check("hold result", result, 32'hFFFFFFD6);
        check("hold rdOut", 32'(rdOut), 32'd3);

        step();
        run_op("div -100/7", 1'b1, 5'd4, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 1'b0);
        step();
        run_op("div 5/0", 1'b1, 5'd5, 32'd5, 32'd0, 32'd0, 1'b1);
        step();
        run_op("mul 2^16x2^16", 1'b0, 5'd6, 32'h00010000, 32'h00010000, 32'd0, 1'b1);
        step();
        run_op("div min/-1", 1'b1, 5'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
        step();
        run_op("div -7/-2", 1'b1, 5'd8, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 1'b0);
        step();
        run_op("div 7/-2", 1'b1, 5'd9, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0);
        step();
        run_op("mul min x1", 1'b0, 5'd10, 32'h80000000, 32'd1, 32'h80000000, 1'b0);
        step();
        run_op("mul min x-1", 1'b0, 5'd11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
        step();
        run_op("mul 2^30x2", 1'b0, 5'd12, 32'h40000000, 32'd2, 32'h80000000, 1'b1);

        // back-to-back: second op enters at T+34
        step();
        run_op("b2b 2x3", 1'b0, 5'd13, 32'd2, 32'd3, 32'd6, 1'b0);
        step();
        run_op("b2b 4x5", 1'b0, 5'd14, 32'd4, 32'd5, 32'd20, 1'b0);
        step();
        DXIR = NOP;

        // reset at T+10 of a mult, released at T+12
        step();
        DXIR     = enc(5'd6, 5'd15);
        operandA = 32'd100;
        operandB = 32'd100;
        for (int i = 0; i < 10; i++) step();
        reset = 1'b1;
        #1;
        check("midrst stall", 32'(stall), 32'd0);
        check("midrst rdy", 32'(resultRDY), 32'd0);
        check("midrst result", result, 32'd0);
        check("midrst exc", 32'(exception), 32'd0);
        check("midrst rdOut", 32'(rdOut), 32'd0);
        step();
        check("midrst rdy2", 32'(resultRDY), 32'd0);
        step();
        reset = 1'b0;
        run_op("after rst 9x9", 1'b0, 5'd16, 32'd9, 32'd9, 32'd81, 1'b0);
        step();
        DXIR = NOP;
        #1;
        check("final rdy", 32'(resultRDY), 32'd0);
        check("final stall", 32'(stall), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
